// File: rtl/hazard_forward_unit_pkg.sv
// Shared opcode constants, decoded-instruction record and FSM states for the
// ID-stage hazard/forwarding unit.
package hazard_forward_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic [4:0] dest;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       reads_a;
    logic       reads_b;
    logic       writes;
    logic       is_load;
  } dec_t;

  typedef enum logic {RUN, HOLD} state_t;

  function automatic dec_t decode_instr(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.src_a = w[25:21];
    d.src_b = w[20:16];
    unique case (w[31:26])
      OP_RTYPE: begin
        d.reads_a = 1'b1;
        if (w[5:0] != FN_JR) begin
          d.reads_b = 1'b1;
          d.writes  = 1'b1;
          d.dest    = w[15:11];
        end
      end
      OP_ADDI: begin
        d.reads_a = 1'b1;
        d.writes  = 1'b1;
        d.dest    = w[20:16];
      end
      OP_LW: begin
        d.reads_a = 1'b1;
        d.writes  = 1'b1;
        d.is_load = 1'b1;
        d.dest    = w[20:16];
      end
      OP_SW, OP_BEQ: begin
        d.reads_a = 1'b1;
        d.reads_b = 1'b1;
      end
      default: ;
    endcase
    // $0 is never a real destination, so nothing can match against it.
    if (d.dest == 5'd0) begin
      d.writes  = 1'b0;
      d.is_load = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_instr_decode.sv
// Combinational instruction decoder: raw word to source/dest fields.
import hazard_forward_unit_pkg::*;

module instr_decode (
  input  logic [31:0] instr,
  output dec_t        dec
);
  assign dec = decode_instr(instr);
endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard unit: EX/MEM forward selects, load-use and distance-3 stalls,
// flush squash, over a three-deep history of decoded instructions.
import hazard_forward_unit_pkg::*;

module hazard_forward_unit #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_if,
  input  logic        flush,
  output logic        ex_forward_a,
  output logic        ex_forward_b,
  output logic        mem_forward_a,
  output logic        mem_forward_b,
  output logic        stall
);

  localparam dec_t NOP_DEC = decode_instr(NOP_WORD);

  dec_t   dec, h1, h2, h3;
  state_t state, next_state;
  logic   m1_a, m1_b, m2_a, m2_b, m3_a, m3_b;
  logic   load_use, dist3, live;

  instr_decode u_dec (
    .instr (instr_if),
    .dec   (dec)
  );

  always_comb begin
    m1_a = dec.reads_a & h1.writes & (dec.src_a == h1.dest);
    m1_b = dec.reads_b & h1.writes & (dec.src_b == h1.dest);
    m2_a = dec.reads_a & h2.writes & (dec.src_a == h2.dest);
    m2_b = dec.reads_b & h2.writes & (dec.src_b == h2.dest);
    m3_a = dec.reads_a & h3.writes & (dec.src_a == h3.dest);
    m3_b = dec.reads_b & h3.writes & (dec.src_b == h3.dest);

    load_use = h1.is_load & (m1_a | m1_b);
    // A nearer producer of the same register shadows the MEM-stage one.
    dist3    = (m3_a & ~m1_a & ~m2_a) | (m3_b & ~m1_b & ~m2_b);
    live     = rst & ~flush;

    stall         = live & (load_use | dist3);
    ex_forward_a  = live & ~stall & m1_a & ~h1.is_load;
    ex_forward_b  = live & ~stall & m1_b & ~h1.is_load;
    mem_forward_a = live & m2_a & ~m1_a;
    mem_forward_b = live & m2_b & ~m1_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1 <= NOP_DEC;
      h2 <= NOP_DEC;
      h3 <= NOP_DEC;
    end else begin
      h1 <= (stall | flush) ? NOP_DEC : dec;
      h2 <= h1;
      h3 <= h2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  // The held instruction is re-evaluated against the shifted history, so
  // HOLD needs no gating of its own and always lasts one cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      RUN:     if (stall) next_state = HOLD;
      HOLD:    next_state = RUN;
      default: next_state = RUN;
    endcase
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have a single parameter: NOP_WORD, default 32'h0000_0000, the instruction word used as a pipeline bubble.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port instr_if, input, 32, the instruction word presented to the IF/ID stage register this cycle.
REQ-005 SHALL have port flush, input, 1: taken branch or jump; the instruction now in ID is squashed.
REQ-006 SHALL have port ex_forward_a, output, 1: in ID, select the EX ALU result for operand A (rs).
REQ-007 SHALL have port ex_forward_b, output, 1: in ID, select the EX ALU result for operand B (rt).
REQ-008 SHALL have port mem_forward_a, output, 1: in ID, select the MEM write-back data for operand A.
REQ-009 SHALL have port mem_forward_b, output, 1: in ID, select the MEM write-back data for operand B.
REQ-010 SHALL have port stall, output, 1: hold PC and instr_if, and load NOP_WORD into IF/ID this cycle.

Function
REQ-011 SHALL decode each instruction into the following fields, with all other opcodes treated as no-op:
- R-type (op 0): dest = rd, reads rs and rt; funct 0x08 (jr) reads rs only and has no dest.
- addi (0x08): dest = rt, reads rs.
- lw (0x23): dest = rt, reads rs, is_load = 1.
- sw (0x2B): reads rs and rt, no dest.
- beq (0x04): reads rs and rt, no dest.
- j (0x02): reads nothing, no dest.
REQ-012 SHALL treat a dest of register 0 as "no dest"; no forward and no stall may ever be raised against register 0.
REQ-013 SHALL keep a three-entry history (h1 = instruction now in ID, h2 = in EX, h3 = in MEM) that shifts on every clock edge.
REQ-014 SHALL load h1 with the decoded instr_if when stall = 0, and with NOP_WORD when stall = 1 or flush = 1.
REQ-015 SHALL compute ex_forward_x = 1 when source x of instr_if equals the h1 dest, h1 is not a load, and stall = 0.
REQ-016 SHALL compute mem_forward_x = 1 when source x equals the h2 dest and no h1 match exists on that operand; the h1 match takes priority.
REQ-017 SHALL raise stall on a load-use hazard: any source of instr_if equals the h1 dest and h1 is_load = 1.
REQ-018 SHALL raise stall on a distance-3 hazard: any source of instr_if equals the h3 dest, and neither h1 nor h2 matches that same source.
REQ-019 SHALL implement a state machine with states RUN and HOLD:
- RUN goes to HOLD when stall = 1; HOLD returns to RUN on the next edge.
- In HOLD, stall is recomputed for the held instruction and may not assert for the same hazard twice, since the history has shifted.
REQ-020 SHALL drive all forward outputs and stall combinationally from instr_if and the history, with zero-cycle latency.
REQ-021 SHALL give flush priority over stall: when flush = 1, stall = 0, all forwards = 0, and h1 is loaded with NOP_WORD.

Reset
REQ-022 SHALL, while rst = 0, clear h1, h2 and h3 to NOP_WORD, set the state to RUN, and drive stall and all forward outputs to 0.
REQ-023 SHALL, on reset asserted mid-stall, abandon HOLD with no residual stall after release.

Structure
REQ-024 SHALL place in the shared package: the opcode and funct constants, a decoded-instruction typedef (dest[4:0], src_a[4:0], src_b[4:0], reads_a, reads_b, writes, is_load), and the state enum.
REQ-025 SHALL use one combinational sub-module, instr_decode, instanced once for instr_if; history entries store decoded fields, not raw words.

Verification
REQ-026 SHALL cover these directed scenarios:
- EX forward: add $3,$1,$2 then sub $4,$3,$5 -> ex_forward_a = 1 on the sub fetch, stall = 0.
- MEM forward: add $3,... ; nop ; or $6,$7,$3 -> mem_forward_b = 1 on the or fetch.
- Load-use: lw $8,0($1) then add $9,$8,$8 -> stall = 1 for one cycle, then mem_forward_a = mem_forward_b = 1 with the add held.
- Distance-3 and $0: addi $0,$0,5 followed by any $0 reader -> no flags; add $2,... ; nop ; nop ; add $4,$2,$2 -> one-cycle stall.
- Flush and reset: flush asserted with a lw in h1 -> h1 becomes NOP_WORD and no stall; rst pulled low during HOLD -> all outputs 0, and after release a nop stream gives no flags.
